// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register placed right after the register file.
//
// Captures both read operands (with same-cycle writeback forwarded in), the
// sign-extended immediate, the register specifiers and the decode control bits
// for EX. Detects load-use hazards against the instruction already in EX and
// inserts one bubble per hazard, asking upstream to hold PC and IF/ID.
//
// Optional feature: define STALL_COUNT_EN to build the hazard-bubble counter;
// otherwise stall_count is tied to zero.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   id_valid          decode slot holds a real instruction
//   id_rs/rt/rd       source / source / destination specifiers
//   id_uses_rt        instruction reads rt as a source
//   id_rdata1/2       register file read data for rs / rt
//   id_imm            sign-extended immediate
//   id_ctrl           {regWrite,memRead,memWrite,memToReg,aluSrc,regDst,aluOp[1:0]}
//   wb_reg_write      writeback enable
//   wb_write_reg      writeback destination
//   wb_write_data     writeback data
//   flush             kill the decode-slot instruction
//   stall_o           hold PC and IF/ID this cycle (combinational)
//   ex_valid          EX slot holds a real instruction
//   ex_rs/rt/rd       registered specifiers
//   ex_a, ex_b        registered operands after writeback patch
//   ex_imm            registered immediate
//   ex_ctrl           registered control, zero in a bubble
//   stall_count       number of hazard bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic [31:0]       stall_count
);

  localparam int MEM_READ_BIT = 6;

  // Register 0 reads as zero and is never overwritten by a writeback.
  function automatic logic signed [DATA_W-1:0] wb_patch(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rdata,
    input logic              we,
    input logic [REG_AW-1:0] wreg,
    input logic [DATA_W-1:0] wdata
  );
    if (src == '0)
      return '0;
    else if (we && (wreg == src))
      return wdata;
    else
      return rdata;
  endfunction

  // ---- stage p0: decode slot, operand patch and hazard detection ----
  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic                     hazard_p0;
  logic                     bubble_p0;

  assign op_a_p0 = wb_patch(id_rs, id_rdata1, wb_reg_write, wb_write_reg, wb_write_data);
  assign op_b_p0 = wb_patch(id_rt, id_rdata2, wb_reg_write, wb_write_reg, wb_write_data);

  assign hazard_p0 = ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) &&
                     id_valid;

  // A flush already discards the dependent instruction, so no hold is needed.
  assign stall_o   = hazard_p0 && !flush && rst_n;
  assign bubble_p0 = flush || hazard_p0;

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (!rst_n || bubble_p0) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= 8'h00;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_a     <= op_a_p0;
      ex_b     <= op_b_p0;
      ex_imm   <= id_imm;
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_p1 <= 32'h0;
    else if (stall_o)
      stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
  end

  assign stall_count = stall_cnt_p1;
`else
  assign stall_count = 32'h0;
`endif

endmodule
